hex_display_scheduler: RTL and testbench

Shares one hex-to-seven-segment decoder across NUM_DIGITS board displays (HEX0..HEX5 on the DE-class board). A producer hands over a packed nibble vector through a valid/ready handshake. The block captures it in a shadow register and scans the digits MSB-first, one per clock, through the shared decoder. Each result goes into a per-display segment register that drives the pins. It sits between the top-level switch/LED glue and the HEX outputs, replacing per-display decoder instances.

---
 rtl/hex_display_pkg.sv | 30 +++
 rtl/hex_seg_decoder.sv | 31 +++
 rtl/hex_display_scheduler.sv | 111 +++++++++++
 tb/tb_hex_display_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the multiplexed hex display scheduler.
// Segment bytes are active-low with bit 7 as the (always off) decimal point.
package hex_display_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDone
   } state_e;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [7:0] SEG_0 = 8'hC0;
   localparam logic [7:0] SEG_1 = 8'hF9;
   localparam logic [7:0] SEG_2 = 8'hA4;
   localparam logic [7:0] SEG_3 = 8'hB0;
   localparam logic [7:0] SEG_4 = 8'h99;
   localparam logic [7:0] SEG_5 = 8'h92;
   localparam logic [7:0] SEG_6 = 8'h82;
   localparam logic [7:0] SEG_7 = 8'hF8;
   localparam logic [7:0] SEG_8 = 8'h80;
   localparam logic [7:0] SEG_9 = 8'h90;
   localparam logic [7:0] SEG_A = 8'h88;
   localparam logic [7:0] SEG_B = 8'h83;
   localparam logic [7:0] SEG_C = 8'hC6;
   localparam logic [7:0] SEG_D = 8'hA1;
   localparam logic [7:0] SEG_E = 8'h86;
   localparam logic [7:0] SEG_F = 8'h8E;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment byte decoder (dp off).
module hex_seg_decoder
   import hex_display_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [7:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      unique case (i_nibble)
         4'h0: o_seg = SEG_0;
         4'h1: o_seg = SEG_1;
         4'h2: o_seg = SEG_2;
         4'h3: o_seg = SEG_3;
         4'h4: o_seg = SEG_4;
         4'h5: o_seg = SEG_5;
         4'h6: o_seg = SEG_6;
         4'h7: o_seg = SEG_7;
         4'h8: o_seg = SEG_8;
         4'h9: o_seg = SEG_9;
         4'hA: o_seg = SEG_A;
         4'hB: o_seg = SEG_B;
         4'hC: o_seg = SEG_C;
         4'hD: o_seg = SEG_D;
         4'hE: o_seg = SEG_E;
         4'hF: o_seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/hex_display_scheduler.sv
// Scans a captured nibble vector MSB-first through one shared segment decoder into
// per-display registers. Optional HEX_BLANK_LEADING_ZEROS_EN blanks leading zero digits.
module hex_display_scheduler
   import hex_display_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 6
) (
   input  logic                    CLOCK_50,
   input  logic                    RESET_N,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [8*NUM_DIGITS-1:0] HEX_OUT,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   state_e                  r_state;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [IDX_W-1:0]        r_index;
   logic [8*NUM_DIGITS-1:0] r_hex;
   logic                    r_ready;
   logic                    r_busy;
   logic                    r_done;

   logic                    w_accept;
   logic [3:0]              w_nibble;
   logic [7:0]              w_seg;
   logic [7:0]              w_byte;

   assign w_accept = (r_state == StIdle) && load_valid && r_ready;
   assign w_nibble = r_shadow[r_index*4 +: 4];

   hex_seg_decoder u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

`ifdef HEX_BLANK_LEADING_ZEROS_EN
   logic r_zero_run;

   // Byte 0 always shows a digit so an all-zero value still reads "0".
   assign w_byte = (r_zero_run && (w_nibble == 4'h0) && (r_index != '0)) ? SEG_BLANK : w_seg;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_zero_run <= 1'b0;
      end else if (w_accept) begin
         r_zero_run <= 1'b1;
      end else if ((r_state == StScan) && (w_nibble != 4'h0)) begin
         r_zero_run <= 1'b0;
      end
   end
`else
   assign w_byte = w_seg;
`endif

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state  <= StIdle;
         r_shadow <= '0;
         r_index  <= LAST_IDX;
         r_hex    <= {NUM_DIGITS{SEG_BLANK}};
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_shadow <= load_value;
                  r_index  <= LAST_IDX;
                  r_state  <= StScan;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
               end
            end
            StScan: begin
               // Untouched bytes hold their old value, so the display never flashes blank.
               r_hex[r_index*8 +: 8] <= w_byte;
               if (r_index == '0) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
               end else begin
                  r_index <= r_index - 1'b1;
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = r_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   assign HEX_OUT    = r_hex;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Self-checking bench for hex_display_scheduler: directed loads, mid-scan reset and random
// loads compared against a digit-level display model (honours HEX_BLANK_LEADING_ZEROS_EN).
module tb_hex_display_scheduler;

   localparam int N = 6;

   logic           CLOCK_50 = 1'b0;
   logic           RESET_N;
   logic           load_valid;
   logic           load_ready;
   logic [4*N-1:0] load_value;
   logic [8*N-1:0] HEX_OUT;
   logic           busy;
   logic           done;

   int             total = 0;
   int             bad = 0;
   logic [8*N-1:0] exp_hex;

   hex_display_scheduler #(
      .NUM_DIGITS (N)
   ) dut (
      .CLOCK_50   (CLOCK_50),
      .RESET_N    (RESET_N),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .HEX_OUT    (HEX_OUT),
      .busy       (busy),
      .done       (done)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [7:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 8'hC0;
         4'h1: return 8'hF9;
         4'h2: return 8'hA4;
         4'h3: return 8'hB0;
         4'h4: return 8'h99;
         4'h5: return 8'h92;
         4'h6: return 8'h82;
         4'h7: return 8'hF8;
         4'h8: return 8'h80;
         4'h9: return 8'h90;
         4'hA: return 8'h88;
         4'hB: return 8'h83;
         4'hC: return 8'hC6;
         4'hD: return 8'hA1;
         4'hE: return 8'h86;
         default: return 8'h8E;
      endcase
   endfunction

   // Displayed byte for digit i of value v once its scan step has happened.
   function automatic logic [7:0] model_byte(input logic [4*N-1:0] v, input int i);
`ifdef HEX_BLANK_LEADING_ZEROS_EN
      if (i != 0 && (v >> (4 * i)) == '0) return 8'hFF;
`endif
      return seg_of(v[4*i +: 4]);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk_ctrl(input string tag, input logic rdy, input logic bsy, input logic dn);
      chk({tag, "_ready"}, load_ready, rdy);
      chk({tag, "_busy"}, busy, bsy);
      chk({tag, "_done"}, done, dn);
   endtask

   task automatic idle(input int cycles);
      load_valid = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         tick;
         chk("idle_hex", HEX_OUT, exp_hex);
         chk_ctrl("idle", 1'b1, 1'b0, 1'b0);
      end
   endtask

   // Offer v, then follow the scan cycle by cycle. after_v replaces load_value right after
   // acceptance; abort_at = k asserts reset before scan step k (0 = no abort).
   task automatic run_load(input logic [4*N-1:0] v, input logic [4*N-1:0] after_v,
                           input bit keep_valid, input int abort_at);
      int waited = 0;
      load_value = v;
      load_valid = 1'b1;
      while (!load_ready && waited < 20) begin
         tick;
         waited++;
      end
      chk("accept_ready", load_ready, 1'b1);
      tick;
      load_value = after_v;
      load_valid = keep_valid;
      for (int k = 1; k <= N; k++) begin
         if (abort_at == k) begin
            RESET_N = 1'b0;
            load_valid = 1'b0;
            #1;
            exp_hex = {N{8'hFF}};
            chk("abort_hex", HEX_OUT, exp_hex);
            chk_ctrl("abort", 1'b1, 1'b0, 1'b0);
            tick;
            tick;
            chk("abort_hold_done", done, 1'b0);
            RESET_N = 1'b1;
            tick;
            chk("abort_rel_hex", HEX_OUT, exp_hex);
            chk_ctrl("abort_rel", 1'b1, 1'b0, 1'b0);
            return;
         end
         tick;
         exp_hex[8*(N-k) +: 8] = model_byte(v, N - k);
         chk("scan_hex", HEX_OUT, exp_hex);
         chk_ctrl("scan", 1'b0, 1'b1, (k == N));
      end
      tick;
      chk("post_hex", HEX_OUT, exp_hex);
      chk_ctrl("post", 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [4*N-1:0] v;
      int             ab;

      RESET_N    = 1'b1;
      load_valid = 1'b0;
      load_value = '0;
      exp_hex    = {N{8'hFF}};
      #1;
      RESET_N = 1'b0;
      #1;
      chk("reset_hex", HEX_OUT, {N{8'hFF}});
      chk_ctrl("reset", 1'b1, 1'b0, 1'b0);
      tick;
      tick;
      RESET_N = 1'b1;
      idle(2);

      // Scan uses the captured copy even though load_value moves to FFFFFF with valid held.
      run_load(24'h012345, 24'hFFFFFF, 1'b1, 0);
`ifdef HEX_BLANK_LEADING_ZEROS_EN
      chk("const_012345", HEX_OUT, 48'hFF_F9_A4_B0_99_92);
`else
      chk("const_012345", HEX_OUT, 48'hC0_F9_A4_B0_99_92);
`endif
      run_load(24'hFFFFFF, 24'h000000, 1'b0, 0);
      chk("const_ffffff", HEX_OUT, {N{8'h8E}});
      idle(1);

      // Reset after the third scan cycle, then a fresh load.
      run_load(24'h987654, 24'h0, 1'b0, 4);
      run_load(24'hABCDEF, 24'h0, 1'b0, 0);
      chk("const_abcdef", HEX_OUT, 48'h88_83_C6_A1_86_8E);

      run_load(24'h000400, 24'h0, 1'b0, 0);
`ifdef HEX_BLANK_LEADING_ZEROS_EN
      chk("const_000400", HEX_OUT, 48'hFF_FF_FF_99_C0_C0);
`else
      chk("const_000400", HEX_OUT, 48'hC0_C0_C0_99_C0_C0);
`endif
      run_load(24'h000000, 24'h0, 1'b0, 0);
`ifdef HEX_BLANK_LEADING_ZEROS_EN
      chk("const_000000", HEX_OUT, 48'hFF_FF_FF_FF_FF_C0);
`else
      chk("const_000000", HEX_OUT, {N{8'hC0}});
`endif

      for (int r = 0; r < 24; r++) begin
         idle($urandom_range(0, 3));
         v = 24'($urandom);
         if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(0, N - 1));
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, N) : 0;
         run_load(v, 24'($urandom), $urandom_range(0, 1) == 1, ab);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
